// File: rtl/wb_pipe_reg.sv
`default_nettype none
// ============================================================================
// wb_pipe_reg : MEM->WB pipeline stage, valid/ready, optional skid buffer,
//               flush, write-back value select and wrapping retire counter.
// Revision    : 1.0
// ============================================================================
module wb_pipe_reg #(
  parameter int DATA_W        = 32,
  parameter int REG_AW        = 5,
  parameter int SKID          = 1,
  parameter int ZERO_SUPPRESS = 1,
  parameter int CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_pc_plus,
  input  logic              in_reg_write,
  input  logic              in_mem_to_reg,
  input  logic              in_save_pc,
  input  logic [REG_AW-1:0] in_write_reg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_wb_data,
  output logic [REG_AW-1:0] out_write_reg,
  output logic              out_reg_write,
  output logic [CNT_W-1:0]  retire_count
);

  logic [DATA_W-1:0] w_wb_data;
  logic              w_reg_write;
  logic              w_in_hs;
  logic              w_out_hs;
  logic              w_out_valid;
  logic              w_in_ready;

  logic [DATA_W-1:0] r_main_data;
  logic [REG_AW-1:0] r_main_reg;
  logic              r_main_we;
  logic [CNT_W-1:0]  r_retire;

  // Value selection happens once, at capture; save_pc outranks mem_to_reg.
  assign w_wb_data   = in_save_pc    ? in_pc_plus   :
                       in_mem_to_reg ? in_read_data : in_alu_result;
  assign w_reg_write = in_reg_write &
                       ~((ZERO_SUPPRESS != 0) && (in_write_reg == '0));

  assign w_in_hs  = in_valid & w_in_ready & ~flush;
  assign w_out_hs = w_out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
      } state_t;

      state_t            r_state;
      logic              r_in_ready;
      logic [DATA_W-1:0] r_skid_data;
      logic [REG_AW-1:0] r_skid_reg;
      logic              r_skid_we;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_main_data <= '0;
          r_main_reg  <= '0;
          r_main_we   <= 1'b0;
          r_skid_data <= '0;
          r_skid_reg  <= '0;
          r_skid_we   <= 1'b0;
        end else if (flush) begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
          r_skid_we  <= 1'b0;
        end else begin
          case (r_state)
            S_EMPTY: begin
              if (w_in_hs) begin
                r_main_data <= w_wb_data;
                r_main_reg  <= in_write_reg;
                r_main_we   <= w_reg_write;
                r_state     <= S_FULL;
              end
            end
            S_FULL: begin
              if (w_in_hs && w_out_hs) begin
                r_main_data <= w_wb_data;
                r_main_reg  <= in_write_reg;
                r_main_we   <= w_reg_write;
              end else if (w_in_hs) begin
                r_skid_data <= w_wb_data;
                r_skid_reg  <= in_write_reg;
                r_skid_we   <= w_reg_write;
                r_state     <= S_SKID;
                r_in_ready  <= 1'b0;
              end else if (w_out_hs) begin
                r_state <= S_EMPTY;
              end
            end
            S_SKID: begin
              if (w_out_hs) begin
                r_main_data <= r_skid_data;
                r_main_reg  <= r_skid_reg;
                r_main_we   <= r_skid_we;
                r_state     <= S_FULL;
                r_in_ready  <= 1'b1;
              end
            end
            default: begin
              r_state    <= S_EMPTY;
              r_in_ready <= 1'b1;
            end
          endcase
        end
      end

      // in_ready depends only on registered state and reset, never on out_ready.
      assign w_out_valid = (r_state != S_EMPTY);
      assign w_in_ready  = r_in_ready & rst_n;
    end else begin : g_single
      logic r_valid;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_valid     <= 1'b0;
          r_main_data <= '0;
          r_main_reg  <= '0;
          r_main_we   <= 1'b0;
        end else if (flush) begin
          r_valid <= 1'b0;
        end else if (w_in_hs) begin
          r_valid     <= 1'b1;
          r_main_data <= w_wb_data;
          r_main_reg  <= in_write_reg;
          r_main_we   <= w_reg_write;
        end else if (w_out_hs) begin
          r_valid <= 1'b0;
        end
      end

      assign w_out_valid = r_valid;
      assign w_in_ready  = rst_n & (out_ready | ~r_valid);
    end
  endgenerate

  // Counts committed writes only; a flush never retracts a completed beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_retire <= '0;
    end else if (w_out_hs && r_main_we) begin
      r_retire <= r_retire + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready      = w_in_ready;
  assign out_valid     = w_out_valid;
  assign out_wb_data   = r_main_data;
  assign out_write_reg = r_main_reg;
  assign out_reg_write = r_main_we & w_out_valid;
  assign retire_count  = r_retire;

endmodule
`default_nettype wire

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised MEM→WB pipeline stage with valid/ready flow control, optional two-entry skid buffer, synchronous flush and write-back value selection. It accepts one retiring instruction per cycle from the memory stage, selects the register-file write value (PC+4, load data or ALU result) at capture, and presents a single write-back beat to the register file and forwarding network. A wrapping retire counter provides a committed-write count for debug.

## Interface
- DATA_W, 32, width of data and PC paths
- REG_AW, 5, register-address width
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register, in_ready = out_ready | ~out_valid
- ZERO_SUPPRESS, 1, 1 = force reg_write to 0 when write_reg == 0 at capture
- CNT_W, 16, retire-counter width

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  drop all held beats and any same-cycle input beat
- in_valid  in  1  MEM stage beat valid
- in_ready  out  1  stage can accept a beat
- in_read_data  in  DATA_W  load data
- in_alu_result  in  DATA_W  ALU result
- in_pc_plus  in  DATA_W  incremented PC for link writes
- in_reg_write  in  1  beat writes register file
- in_mem_to_reg  in  1  select load data
- in_save_pc  in  1  select in_pc_plus (priority over in_mem_to_reg)
- in_write_reg  in  REG_AW  destination register
- out_valid  out  1  WB beat valid
- out_ready  in  1  WB consumer accepts beat
- out_wb_data  out  DATA_W  selected write-back value
- out_write_reg  out  REG_AW  destination register
- out_reg_write  out  1  = stored reg_write & out_valid
- retire_count  out  CNT_W  committed register writes, wraps

## Operation
- Selection at capture: wb_data = save_pc ? pc_plus : mem_to_reg ? read_data : alu_result; stored entry = {wb_data, write_reg, reg_write'}, reg_write' = reg_write & ~(ZERO_SUPPRESS & write_reg==0).
- Input handshake: in_valid & in_ready & ~flush. Output handshake: out_valid & out_ready.
- SKID=1 states: EMPTY (out_valid 0, in_ready 1), FULL (main valid, in_ready 1), SKID (main + skid valid, in_ready 0).
  - EMPTY: input hs → FULL.
  - FULL: input hs & ~out hs → SKID (new beat to skid); input hs & out hs → FULL (new beat to main); out hs only → EMPTY.
  - SKID: out hs → FULL (skid moves to main); else hold.
- SKID=0: one register; loads on input hs; out_valid clears on out hs without input hs; in_ready combinational.
- Flush: next state EMPTY, skid cleared; out hs in flush cycle completes and counts; input beat in flush cycle dropped; stored data fields not required to clear.
- retire_count increments by 1 on out hs with out_reg_write = 1; wraps 2^CNT_W−1 → 0; unaffected by flush.
- Order preserved: beats leave in acceptance order, none duplicated or lost except by flush.

## Timing
- Reset (rst_n low at rising edge): out_valid 0, out_reg_write 0, out_wb_data 0, out_write_reg 0, retire_count 0, state EMPTY; in_ready 0 while rst_n low, 1 on first cycle after release.
- Reset mid-operation discards all held beats; no handshake is counted in the reset cycle.
- Latency: beat accepted at edge N visible on outputs after edge N (out_valid high in cycle N+1).
- Throughput: 1 beat/cycle while out_ready high; SKID=1 absorbs one extra beat after out_ready drops, then in_ready falls (registered, next cycle).
- Outputs held stable while out_valid & ~out_ready.
- SKID=1: no combinational path out_ready → in_ready.

## Test plan
- Reset then stream 4 beats, out_ready=1, alu=0x10,0x11,0x12,0x13, reg 1..4 → out_wb_data same order cycles 1–4 after accept, retire_count=4.
- Select: beat A save_pc=1,mem_to_reg=1,pc=0x104 → 0x104; beat B mem_to_reg=1,read=0xDEADBEEF → 0xDEADBEEF; beat C write_reg=0,reg_write=1 → out_reg_write 0, retire_count unchanged.
- SKID=1 backpressure: drop out_ready with beats X,Y,Z offered continuously → X held on outputs, Y in skid, in_ready 0, Z not accepted; raise out_ready → X,Y,Z in order, no loss.
- Flush in SKID state with in_valid=1 and out_ready=0 → next cycle out_valid 0, in_ready 1, neither held beat nor input beat ever appears, retire_count unchanged.
- CNT_W=4: 17 writing beats → retire_count 1; rst_n low mid-stream for 1 cycle → out_valid 0, retire_count 0 next cycle.
- SKID=0: out_ready=0 with out_valid=1 → in_ready 0 same cycle; out_ready=1 and in_valid=1 → simultaneous replace, out_valid stays 1.
